// File: rtl/decoder3x8_seq.sv
// rtl/decoder3x8_seq.sv - queued 3-to-8 decoder replaying each code as a held one-hot word
// Codes enter through a small pointer-wrapped FIFO; a three-state sequencer drives, gaps and idles.
module decoder3x8_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       done,
  output logic       busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP > 0) ? CW'(GAP - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic          done_q, done_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];

  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic [2:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_code;
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_DRIVE;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (GAP > 0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else if (!empty) begin
          pop   = 1'b1;
          cnt_d = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = S_DRIVE;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A pop always loads a fresh word; otherwise DRIVE keeps the current word.
  always_comb begin
    if (pop) begin
      y_d = 8'd1 << head;
    end else if (state_d == S_DRIVE) begin
      y_d = y_q;
    end else begin
      y_d = '0;
    end
    y_valid_d = (state_d == S_DRIVE);
    done_d    = (state_d == S_DRIVE) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_decoder3x8_seq.sv
// tb/tb_decoder3x8_seq.sv - bench for decoder3x8_seq (GAP=1 and GAP=0 instances)
// Reference model schedules each accepted code by start edge and derives all outputs from that.
module tb_decoder3x8_seq;

  localparam int HOLD_P  = 4;
  localparam int DEPTH_P = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       in_ready_a, y_valid_a, done_a, busy_a;
  logic       in_ready_b, y_valid_b, done_b, busy_b;
  logic [7:0] y_a, y_b;

  always #5 clk = ~clk;

  decoder3x8_seq #(.HOLD(HOLD_P), .GAP(1), .DEPTH(DEPTH_P)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_code(in_code), .y(y_a), .y_valid(y_valid_a), .done(done_a), .busy(busy_a)
  );

  decoder3x8_seq #(.HOLD(HOLD_P), .GAP(0), .DEPTH(DEPTH_P)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_code(in_code), .y(y_b), .y_valid(y_valid_b), .done(done_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per instance, each accepted code has accept edge, start edge and code value.
  int m_acc [2][1024];
  int m_st  [2][1024];
  int m_cd  [2][1024];
  int m_n   [2];
  int m_end [2];
  int t = 0;

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int occ_after(input int k, input int e);
    int n = 0;
    for (int i = 0; i < m_n[k]; i++)
      if (m_acc[k][i] <= e && m_st[k][i] > e) n++;
    return n;
  endfunction

  task automatic check_dut(input int k, input logic [7:0] yy, input logic yv,
                           input logic dn, input logic bs, input logic rd);
    string p;
    int ey, ed, eb;
    p = (k == 0) ? "a_" : "b_";
    chk({p, "onehot"}, int'($countones(yy) <= 1), 1);
    if (!rst_n) begin
      chk({p, "rst_y"}, yy, 0);
      chk({p, "rst_valid"}, yv, 0);
      chk({p, "rst_done"}, dn, 0);
      chk({p, "rst_busy"}, bs, 0);
      chk({p, "rst_ready"}, rd, 0);
    end else begin
      ey = 0; ed = 0; eb = 0;
      for (int i = 0; i < m_n[k]; i++) begin
        if (t >= m_st[k][i] && t < m_st[k][i] + HOLD_P) ey = 1 << m_cd[k][i];
        if (t == m_st[k][i] + HOLD_P - 1) ed = 1;
        if (t >= m_st[k][i] && t < m_st[k][i] + HOLD_P + gap_of(k)) eb = 1;
      end
      if (occ_after(k, t) > 0) eb = 1;
      chk({p, "y"}, yy, ey);
      chk({p, "y_valid"}, yv, int'(ey != 0));
      chk({p, "done"}, dn, ed);
      chk({p, "busy"}, bs, eb);
      chk({p, "in_ready"}, rd, int'(occ_after(k, t) < DEPTH_P));
    end
  endtask

  logic [7:0] log_a[$], log_b[$];
  logic [7:0] prev_a = '0, prev_b = '0;
  int nz_a = 0, nz_b = 0, dn_a = 0, dn_b = 0;

  initial begin
    logic cv, cr;
    logic [2:0] cc;
    forever begin
      @(posedge clk);
      cv = in_valid; cc = in_code; cr = rst_n;
      if (!cr) begin
        m_n[0] = 0; m_n[1] = 0;
        m_end[0] = -1000; m_end[1] = -1000;
      end else begin
        t++;
        for (int k = 0; k < 2; k++) begin
          if (cv && occ_after(k, t - 1) < DEPTH_P && m_n[k] < 1024) begin
            m_acc[k][m_n[k]] = t;
            m_st[k][m_n[k]]  = (m_end[k] > t + 1) ? m_end[k] : t + 1;
            m_cd[k][m_n[k]]  = int'(cc);
            m_end[k] = m_st[k][m_n[k]] + HOLD_P + gap_of(k);
            m_n[k]++;
          end
        end
      end
      @(negedge clk);
      check_dut(0, y_a, y_valid_a, done_a, busy_a, in_ready_a);
      check_dut(1, y_b, y_valid_b, done_b, busy_b, in_ready_b);
      if (y_a != prev_a && y_a != 0) log_a.push_back(y_a);
      if (y_b != prev_b && y_b != 0) log_b.push_back(y_b);
      prev_a = y_a; prev_b = y_b;
      if (y_a != 0) nz_a++;
      if (y_b != 0) nz_b++;
      if (done_a) dn_a++;
      if (done_b) dn_b++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_mon();
    log_a.delete(); log_b.delete();
    nz_a = 0; nz_b = 0; dn_a = 0; dn_b = 0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy_a || busy_b) && w < 60) begin
      tick();
      w++;
    end
    chk("drain", int'(busy_a | busy_b), 0);
  endtask

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[8];
  int   codes[4];
  int   acc[4];

  initial begin
    int idx, it, w;
    logic rdy;
    vecs[0] = '{3'd0, 8'h01}; vecs[1] = '{3'd1, 8'h02};
    vecs[2] = '{3'd2, 8'h04}; vecs[3] = '{3'd3, 8'h08};
    vecs[4] = '{3'd4, 8'h10}; vecs[5] = '{3'd5, 8'h20};
    vecs[6] = '{3'd6, 8'h40}; vecs[7] = '{3'd7, 8'h80};
    codes[0] = 1; codes[1] = 2; codes[2] = 3; codes[3] = 4;

    // Reset held with in_valid asserted
    in_valid = 1'b1; in_code = 3'd5;
    repeat (3) tick();
    chk("rst_hold_y", y_a, 0);
    chk("rst_hold_ready", in_ready_a, 0);
    chk("rst_hold_busy", busy_b, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_release_ready", in_ready_a, 1);
    clear_mon();
    repeat (3) tick();
    chk("rst_nothing_queued", int'(busy_a | busy_b), 0);
    chk("rst_no_output", nz_a + nz_b, 0);

    // Single code 5
    clear_mon();
    in_valid = 1'b1; in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("single_cycles", nz_a, 4);
    chk("single_done", dn_a, 1);
    chk("single_words", log_a.size(), 1);
    if (log_a.size() > 0) chk("single_word", log_a[0], 8'h20);
    chk("single_idle", busy_a, 0);

    // Back-to-back 0 then 7
    clear_mon();
    in_valid = 1'b1; in_code = 3'd0;
    tick();
    in_code = 3'd7;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    chk("b2b_words", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("b2b_first", log_a[0], 8'h01);
      chk("b2b_second", log_a[1], 8'h80);
    end
    chk("b2b_done", dn_a, 2);
    chk("b2b_cycles", nz_a, 8);
    wait_idle();

    // Full queue with handshake on instance a
    clear_mon();
    in_valid = 1'b1; idx = 0; it = 0;
    while (idx < 4 && it < 30) begin
      in_code = 3'(codes[idx]);
      rdy = in_ready_a;
      tick();
      if (rdy) begin
        acc[idx] = it;
        idx++;
      end
      it++;
    end
    in_valid = 1'b0;
    chk("fullq_accepted", idx, 4);
    chk("fullq_third", acc[2] - acc[0], 2);
    chk("fullq_stall", acc[3] - acc[0], 7);
    repeat (25) tick();
    chk("fullq_words", log_a.size(), 4);
    if (log_a.size() == 4) begin
      chk("fullq_w0", log_a[0], 8'h02);
      chk("fullq_w1", log_a[1], 8'h04);
      chk("fullq_w2", log_a[2], 8'h08);
      chk("fullq_w3", log_a[3], 8'h10);
    end
    wait_idle();

    // Reset during the second DRIVE cycle of code 3 with code 6 queued
    in_valid = 1'b1; in_code = 3'd3;
    tick();
    in_code = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midrst_driving", y_a, 8'h08);
    rst_n = 1'b0;
    #1;
    chk("midrst_y_a", y_a, 0);
    chk("midrst_y_b", y_b, 0);
    chk("midrst_valid", y_valid_a, 0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (20) tick();
    chk("midrst_no_resume_a", log_a.size(), 0);
    chk("midrst_no_resume_b", log_b.size(), 0);

    // GAP=0 instance: same code twice runs continuously
    clear_mon();
    in_valid = 1'b1; in_code = 3'd2;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    chk("gap0_cycles", nz_b, 8);
    chk("gap0_done", dn_b, 2);
    chk("gap0_runs", log_b.size(), 1);
    chk("gap1_runs", log_a.size(), 2);
    wait_idle();

    // Table sweep over all codes
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_code = vecs[i].code;
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!y_valid_a && w < 10) begin
        tick();
        w++;
      end
      chk("sweep_latency", w, 1);
      chk("sweep_y_a", y_a, vecs[i].exp_y);
      chk("sweep_y_b", y_b, vecs[i].exp_y);
      wait_idle();
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    wait_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
